// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution layer engine.
//   conv_state_e : engine sequencing states
//   conv_out_dim : output extent of a padded, strided convolution
//   conv_addr_w  : index/address width for a range of n entries (minimum 1)
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BIAS     = 3'd1,
    MAC      = 3'd2,
    DRAIN    = 3'd3,
    OUT      = 3'd4,
    DONE     = 3'd5,
    WAIT_LOW = 3'd6
  } conv_state_e;

  function automatic int conv_out_dim(input int in, input int k, input int pad, input int stride);
    return (in + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int conv_addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_mac_acc.sv
// conv_mac_acc: accumulator datapath of the convolution engine.
//   load      : acc <= sign-extended bias_data (first MAC cycle of a pixel)
//   accum     : acc += fmap_data * wgt_data, gated to zero when tap_ok = 0
//   capture   : register the post-processed next accumulator value as result
//   result    : DATA_W pixel value (saturated or wrapped, then optional ReLU)
// Build option: CONV_LAYER_ENGINE_SAT_EN selects saturation instead of wrap.
module conv_mac_acc #(
  parameter int DATA_W = 32,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 48,
  parameter int RELU   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     accum,
  input  logic                     tap_ok,
  input  logic                     capture,
  input  logic signed [DATA_W-1:0] bias_data,
  input  logic signed [DATA_W-1:0] fmap_data,
  input  logic signed [WGT_W-1:0]  wgt_data,
  output logic        [DATA_W-1:0] result
);

  logic signed [DATA_W+WGT_W-1:0] prod;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        acc_nxt;
  logic        [DATA_W-1:0]       sat_val;
  logic        [DATA_W-1:0]       res_nxt;

  assign prod = fmap_data * wgt_data;

  always_comb begin
    acc_nxt = acc;
    if (load)
      acc_nxt = ACC_W'(bias_data);
    else if (accum && tap_ok)
      acc_nxt = acc + ACC_W'(prod);
  end

`ifdef CONV_LAYER_ENGINE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    if (acc_nxt > SAT_MAX)
      sat_val = SAT_MAX[DATA_W-1:0];
    else if (acc_nxt < SAT_MIN)
      sat_val = SAT_MIN[DATA_W-1:0];
    else
      sat_val = acc_nxt[DATA_W-1:0];
  end
`else
  assign sat_val = acc_nxt[DATA_W-1:0];
`endif

  always_comb begin
    res_nxt = sat_val;
    if (RELU != 0 && sat_val[DATA_W-1])
      res_nxt = '0;
  end

  // result is taken from acc_nxt so it is ready the cycle the last tap lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      acc <= acc_nxt;
      if (capture)
        result <= res_nxt;
    end
  end

endmodule

// File: rtl/conv_layer_engine.sv
// conv_layer_engine: memory-fed 2D convolution layer, one MAC per cycle.
//   start/busy/done         : layer control
//   fmap/wgt/bias rd ports  : synchronous reads, data one cycle after strobe
//   out_valid/out_ready     : one output pixel per handshake, with
//                             out_data/out_ch/out_row/out_col
// Build option: CONV_LAYER_ENGINE_SAT_EN (saturate instead of wrap, see
// conv_mac_acc).
//
// state    | meaning
// IDLE     | waiting for start
// BIAS     | bias read strobe for filter f
// MAC      | N_TAPS cycles, tap t issued in MAC cycle t
// DRAIN    | last tap product lands in the accumulator
// OUT      | pixel presented, held until out_ready
// DONE     | one-cycle done pulse
// WAIT_LOW | wait for start to drop before re-arming
module conv_layer_engine
  import conv_pkg::*;
#(
  parameter int IN_CH  = 16,
  parameter int OUT_CH = 32,
  parameter int IN_H   = 14,
  parameter int IN_W   = 14,
  parameter int K      = 3,
  parameter int PAD    = 1,
  parameter int STRIDE = 1,
  parameter int DATA_W = 32,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 48,
  parameter int RELU   = 1,
  localparam int OUT_H = conv_out_dim(IN_H, K, PAD, STRIDE),
  localparam int OUT_W = conv_out_dim(IN_W, K, PAD, STRIDE),
  localparam int FM_AW = conv_addr_w(IN_CH * IN_H * IN_W),
  localparam int WG_AW = conv_addr_w(OUT_CH * IN_CH * K * K),
  localparam int CH_W  = conv_addr_w(OUT_CH),
  localparam int ROW_W = conv_addr_w(OUT_H),
  localparam int COL_W = conv_addr_w(OUT_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fmap_rd_en,
  output logic [FM_AW-1:0]  fmap_rd_addr,
  input  logic [DATA_W-1:0] fmap_rd_data,
  output logic              wgt_rd_en,
  output logic [WG_AW-1:0]  wgt_rd_addr,
  input  logic [WGT_W-1:0]  wgt_rd_data,
  output logic              bias_rd_en,
  output logic [CH_W-1:0]   bias_rd_addr,
  input  logic [DATA_W-1:0] bias_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col
);

  localparam int N_TAPS = IN_CH * K * K;
  localparam int TAP_W  = conv_addr_w(N_TAPS);
  localparam int IC_W   = conv_addr_w(IN_CH);
  localparam int KI_W   = conv_addr_w(K);

  conv_state_e      state;
  logic [CH_W-1:0]  f;
  logic [ROW_W-1:0] oy;
  logic [COL_W-1:0] ox;
  logic [IC_W-1:0]  tc;
  logic [KI_W-1:0]  tm;
  logic [KI_W-1:0]  tn;
  logic [TAP_W-1:0] mac_left;
  logic             first_mac;
  logic             tap_live;

  int               iy;
  int               ix;
  logic             tap_inb;
  logic [FM_AW-1:0] fm_addr_c;
  logic [WG_AW-1:0] wg_addr_c;
  logic             last_tn, last_tm;
  logic             last_f, last_oy, last_ox, last_pix;
  logic [CH_W-1:0]  f_nxt;
  logic [ROW_W-1:0] oy_nxt;
  logic [COL_W-1:0] ox_nxt;
  logic             issue;

  // tc/tm/tn always name the tap whose strobe is registered on this edge
  always_comb begin
    iy        = int'(oy) * STRIDE + int'(tm) - PAD;
    ix        = int'(ox) * STRIDE + int'(tn) - PAD;
    tap_inb   = (iy >= 0) && (iy < IN_H) && (ix >= 0) && (ix < IN_W);
    fm_addr_c = FM_AW'(int'(tc) * IN_H * IN_W + iy * IN_W + ix);
    wg_addr_c = WG_AW'(((int'(f) * IN_CH + int'(tc)) * K + int'(tm)) * K + int'(tn));
    last_tn   = (tn == KI_W'(K - 1));
    last_tm   = (tm == KI_W'(K - 1));
    last_f    = (f  == CH_W'(OUT_CH - 1));
    last_oy   = (oy == ROW_W'(OUT_H - 1));
    last_ox   = (ox == COL_W'(OUT_W - 1));
    last_pix  = last_f && last_oy && last_ox;
    ox_nxt    = last_ox ? '0 : ox + 1'b1;
    oy_nxt    = last_ox ? (last_oy ? '0 : oy + 1'b1) : oy;
    f_nxt     = (last_ox && last_oy) ? (last_f ? '0 : f + 1'b1) : f;
    issue     = (state == BIAS) || ((state == MAC) && (mac_left != '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      fmap_rd_en   <= 1'b0;
      fmap_rd_addr <= '0;
      wgt_rd_en    <= 1'b0;
      wgt_rd_addr  <= '0;
      bias_rd_en   <= 1'b0;
      bias_rd_addr <= '0;
      out_valid    <= 1'b0;
      out_ch       <= '0;
      out_row      <= '0;
      out_col      <= '0;
      f            <= '0;
      oy           <= '0;
      ox           <= '0;
      tc           <= '0;
      tm           <= '0;
      tn           <= '0;
      mac_left     <= '0;
      first_mac    <= 1'b0;
      tap_live     <= 1'b0;
    end else begin
      done       <= 1'b0;
      bias_rd_en <= 1'b0;
      wgt_rd_en  <= 1'b0;
      fmap_rd_en <= 1'b0;
      first_mac  <= (state == BIAS);
      // fmap_rd_en delayed one cycle marks whether the data now on
      // fmap_rd_data belongs to a real (unpadded) tap
      tap_live   <= fmap_rd_en;

      if (issue) begin
        wgt_rd_en   <= 1'b1;
        wgt_rd_addr <= wg_addr_c;
        fmap_rd_en  <= tap_inb;
        if (tap_inb)
          fmap_rd_addr <= fm_addr_c;
        if (last_tn) begin
          tn <= '0;
          if (last_tm) begin
            tm <= '0;
            tc <= tc + 1'b1;
          end else begin
            tm <= tm + 1'b1;
          end
        end else begin
          tn <= tn + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            f            <= '0;
            oy           <= '0;
            ox           <= '0;
            tc           <= '0;
            tm           <= '0;
            tn           <= '0;
            busy         <= 1'b1;
            bias_rd_en   <= 1'b1;
            bias_rd_addr <= '0;
            state        <= BIAS;
          end
        end
        BIAS: begin
          mac_left <= TAP_W'(N_TAPS - 1);
          state    <= MAC;
        end
        MAC: begin
          if (mac_left == '0)
            state <= DRAIN;
          else
            mac_left <= mac_left - 1'b1;
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_ch    <= f;
          out_row   <= oy;
          out_col   <= ox;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_pix) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              f            <= f_nxt;
              oy           <= oy_nxt;
              ox           <= ox_nxt;
              tc           <= '0;
              tm           <= '0;
              tn           <= '0;
              bias_rd_en   <= 1'b1;
              bias_rd_addr <= f_nxt;
              state        <= BIAS;
            end
          end
        end
        DONE: state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!start)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_mac_acc #(
    .DATA_W(DATA_W),
    .WGT_W (WGT_W),
    .ACC_W (ACC_W),
    .RELU  (RELU)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == MAC) && first_mac),
    .accum    (((state == MAC) && !first_mac) || (state == DRAIN)),
    .tap_ok   (tap_live),
    .capture  (state == DRAIN),
    .bias_data(bias_rd_data),
    .fmap_data(fmap_rd_data),
    .wgt_data (wgt_rd_data),
    .result   (out_data)
  );

endmodule
